pipe_seq_ctrl: RTL and testbench
================================

// Module: pipe_seq_ctrl
// PURPOSE
//  Sequences the 5-stage EV22 pipeline from the hazard unit's HOLD, the stage-2 jump resolution and the stage-4 memory handshake.
//  Drives the per-stage register enables, bubble insertion into stage 3 and the stage 1/2 flush.
//  Keeps a sticky memory-timeout flag and a saturating stall-cycle counter.
//  Sits beside the hazard unit, between it and the pipeline registers.
// PARAMETERS
//  TO_CYCLES  15  max cycles in MEMW waiting for mem_ack before timeout (>=1)
//  FLUSH_CYC  3   bubble cycles inserted into stage 3 after a taken jump (>=1)
//  CNT_W      16  width of stall_cnt
// PORTS
//  clk          in   1      clock, rising edge
//  nreset       in   1      reset; one clock, asynchronous, active-low
//  hold         in   1      HOLD from hazard unit (stage-2 instr must wait)
//  jump_taken   in   1      stage-2 jump resolved taken (valid only when hold=0)
//  mem_req      in   1      stage-4 instr accesses memory this cycle
//  mem_ack      in   1      memory access complete (may coincide with mem_req)
//  en_if        out  1      PC / stage-1 register enable
//  en_id        out  1      stage 1->2 register enable
//  en_ex        out  1      stage 2->3 register enable
//  en_mem       out  1      stage 3->4 and 4->5 register enables
//  bubble3      out  1      load NOP (Type=0) into stage 3 instead of stage 2 instr
//  flush12      out  1      clear stages 1 and 2 on next edge
//  mem_timeout  out  1      sticky: a memory wait hit TO_CYCLES
//  stall_cnt    out  CNT_W  cycles with en_if=0, saturating
//  state        out  2      FSM state, debug
// BEHAVIOUR
//  Outputs are combinational from the registered state and the current inputs. State, counters and flags update on the rising clk edge.
//  States: START=0, RUN=1, MEMW=2, FLUSH=3. Reset forces state=START, mem_timeout=0, stall_cnt=0, wait/flush counters=0, ret=RUN.
//  START: all enables 0, flush12=1, bubble3=0. Next state is RUN unconditionally.
//  RUN, priority high->low:
//   1. mem_req&!mem_ack: all enables 0. Load ret=RUN and wait counter=1. Next state MEMW.
//   2. hold=1: en_if=en_id=0, en_ex=en_mem=1, bubble3=1. Stay in RUN.
//   3. jump_taken=1: all enables 1, flush12=1. Load flush counter=FLUSH_CYC. Next state FLUSH.
//   4. Otherwise: all enables 1, bubble3=0, flush12=0.
//  FLUSH:
//   - Default: en_if=en_id=1, en_ex=en_mem=1, bubble3=1. hold and jump_taken are ignored.
//   - The flush counter decrements each cycle. Go to RUN in the cycle it reads 1.
//   - mem_req&!mem_ack freezes all enables. Save ret=FLUSH, keep the flush counter, go to MEMW.
//  MEMW:
//   - All enables 0, bubble3=0.
//   - mem_ack=1: this cycle drives the outputs of state ret with no new events (RUN rule 4 / FLUSH default). Next state is ret.
//   - Otherwise, when the wait counter == TO_CYCLES: set mem_timeout and release as if acked, next state ret.
//   - Otherwise the wait counter increments.
//  mem_req with mem_ack in the same cycle never stalls.
//  stall_cnt: +1 on every cycle with en_if=0, including START and MEMW. Holds at 2^CNT_W-1.
//  mem_timeout is cleared only by reset.
//  Reset asserted mid-MEMW or mid-FLUSH aborts immediately to START. No pending state is kept.
// TESTING
//  T1 reset release, all inputs 0 -> 1 cycle START (flush12=1, enables 0), then RUN with all enables 1; stall_cnt=1.
//  T2 hold=1 for 2 cycles in RUN -> en_if=en_id=0, bubble3=1, en_ex=en_mem=1 both cycles; stall_cnt +2.
//  T3 jump_taken pulse, FLUSH_CYC=3 -> flush12=1 for 1 cycle, then bubble3=1 for exactly 3 cycles, then RUN. hold=1 during FLUSH has no effect.
//  T4 mem_req=1, mem_ack arrives 4 cycles later -> enables 0 for 4 cycles, enables 1 in the ack cycle, then RUN. mem_timeout=0.
//  T5 mem_req=1, mem_ack never, TO_CYCLES=15 -> freeze lasts 15 cycles, then mem_timeout=1 sticky and RUN.
//  T6 mem stall entered 1 cycle into FLUSH, acked after 2 cycles -> returns to FLUSH with 2 bubble cycles remaining. nreset pulse in MEMW -> START.

Source files
------------

// File: rtl/pipe_seq_if.sv
// Handshake bundle between the hazard unit / memory stage and the pipeline sequencer.
// The master side drives the hazard and memory requests; the slave side is the sequencer.
interface pipe_seq_if #(
    parameter int CNT_W = 16
);
    logic             hold;
    logic             jump_taken;
    logic             mem_req;
    logic             mem_ack;
    logic             en_if;
    logic             en_id;
    logic             en_ex;
    logic             en_mem;
    logic             bubble3;
    logic             flush12;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       state;

    modport master (
        output hold, jump_taken, mem_req, mem_ack,
        input  en_if, en_id, en_ex, en_mem, bubble3, flush12, mem_timeout, stall_cnt, state
    );

    modport slave (
        input  hold, jump_taken, mem_req, mem_ack,
        output en_if, en_id, en_ex, en_mem, bubble3, flush12, mem_timeout, stall_cnt, state
    );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// EV22 5-stage pipeline sequencer: stage enables, stage-3 bubbles, stage-1/2 flush,
// memory-wait timeout flag and a saturating stall-cycle counter.
//
// state | meaning
// START | post-reset cycle, pipeline frozen, stages 1/2 cleared
// RUN   | normal issue, hazard HOLD and jump resolution
// MEMW  | waiting on mem_ack for the stage-4 access
// FLUSH | feeding bubbles into stage 3 after a taken jump
module pipe_seq_ctrl #(
    parameter int TO_CYCLES = 15,
    parameter int FLUSH_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic      clk,
    input  logic      nreset,
    pipe_seq_if.slave bus
);
    localparam int WC_W = $clog2(TO_CYCLES + 1);
    localparam int FC_W = $clog2(FLUSH_CYC + 1);

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        MEMW  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [WC_W-1:0]  wait_q, wait_d;
    logic [FC_W-1:0]  flush_q, flush_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic en_if, en_id, en_ex, en_mem, bubble3, flush12;
    logic mem_stall;

    assign mem_stall = bus.mem_req & ~bus.mem_ack;

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        wait_d    = wait_q;
        flush_d   = flush_q;
        timeout_d = timeout_q;
        en_if     = 1'b0;
        en_id     = 1'b0;
        en_ex     = 1'b0;
        en_mem    = 1'b0;
        bubble3   = 1'b0;
        flush12   = 1'b0;

        case (state_q)
            START: begin
                flush12 = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (mem_stall) begin
                    ret_d   = RUN;
                    wait_d  = WC_W'(1);
                    state_d = MEMW;
                end else if (bus.hold) begin
                    en_ex   = 1'b1;
                    en_mem  = 1'b1;
                    bubble3 = 1'b1;
                end else if (bus.jump_taken) begin
                    {en_if, en_id, en_ex, en_mem} = 4'b1111;
                    flush12 = 1'b1;
                    flush_d = FC_W'(FLUSH_CYC);
                    state_d = FLUSH;
                end else begin
                    {en_if, en_id, en_ex, en_mem} = 4'b1111;
                end
            end
            FLUSH: begin
                // A memory stall parks the flush with its remaining count intact.
                if (mem_stall) begin
                    ret_d   = FLUSH;
                    wait_d  = WC_W'(1);
                    state_d = MEMW;
                end else begin
                    {en_if, en_id, en_ex, en_mem} = 4'b1111;
                    bubble3 = 1'b1;
                    flush_d = flush_q - FC_W'(1);
                    if (flush_q == FC_W'(1)) state_d = RUN;
                end
            end
            MEMW: begin
                // Release cycle behaves like the return state with no new events.
                if (bus.mem_ack || (wait_q == WC_W'(TO_CYCLES))) begin
                    if (!bus.mem_ack) timeout_d = 1'b1;
                    {en_if, en_id, en_ex, en_mem} = 4'b1111;
                    bubble3 = (ret_q == FLUSH);
                    state_d = ret_q;
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end
            default: state_d = START;
        endcase

        stall_d = stall_q;
        if (!en_if && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= START;
            ret_q     <= RUN;
            wait_q    <= '0;
            flush_q   <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            wait_q    <= wait_d;
            flush_q   <= flush_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.en_if       = en_if;
    assign bus.en_id       = en_id;
    assign bus.en_ex       = en_ex;
    assign bus.en_mem      = en_mem;
    assign bus.bubble3     = bubble3;
    assign bus.flush12     = flush12;
    assign bus.mem_timeout = timeout_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl: each step drives {hold,jump,req,ack} at the falling edge
// and compares the hand-computed outputs, state, stall count and timeout flag 1ns later.
module tb_pipe_seq_ctrl;
    localparam logic [5:0] E_OFF   = 6'b000000;
    localparam logic [5:0] E_START = 6'b000001;
    localparam logic [5:0] E_RUN   = 6'b111100;
    localparam logic [5:0] E_HOLD  = 6'b001110;
    localparam logic [5:0] E_JUMP  = 6'b111101;
    localparam logic [5:0] E_BUB   = 6'b111110;
    localparam logic [1:0] S_ST = 2'd0, S_RUN = 2'd1, S_MW = 2'd2, S_FL = 2'd3;

    typedef struct packed {
        logic [3:0] in;
        logic [5:0] out;
        logic [1:0] st;
        logic       to;
    } step_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic [15:0] exp_stall;
    logic [5:0]  outs;
    int          checks = 0;
    int          failures = 0;

    pipe_seq_if #(.CNT_W(16)) bus();

    pipe_seq_ctrl #(.TO_CYCLES(15), .FLUSH_CYC(3), .CNT_W(16)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign outs = {bus.en_if, bus.en_id, bus.en_ex, bus.en_mem, bus.bubble3, bus.flush12};

    task automatic test_reset();
        step_t s[$];
        nreset = 1'b0;
        {bus.hold, bus.jump_taken, bus.mem_req, bus.mem_ack} = 4'b0000;
        exp_stall = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.state !== S_ST) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", bus.state, S_ST); end
        checks++; if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", bus.stall_cnt); end
        checks++; if (bus.mem_timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", bus.mem_timeout); end
        checks++; if (outs !== E_START) begin failures++; $display("FAIL rst_outs got=%b exp=%b", outs, E_START); end
        @(negedge clk);
        nreset = 1'b1;
        s.push_back({4'b0000, E_START, S_ST,  1'b0});
        s.push_back({4'b0000, E_RUN,   S_RUN, 1'b0});
        foreach (s[i]) begin
            {bus.hold, bus.jump_taken, bus.mem_req, bus.mem_ack} = s[i].in;
            #1;
            checks++; if (outs !== s[i].out) begin failures++; $display("FAIL start_outs step=%0d got=%b exp=%b", i, outs, s[i].out); end
            checks++; if (bus.state !== s[i].st) begin failures++; $display("FAIL start_state step=%0d got=%0d exp=%0d", i, bus.state, s[i].st); end
            checks++; if (bus.stall_cnt !== exp_stall) begin failures++; $display("FAIL start_stall step=%0d got=%0d exp=%0d", i, bus.stall_cnt, exp_stall); end
            checks++; if (bus.mem_timeout !== s[i].to) begin failures++; $display("FAIL start_timeout step=%0d got=%b exp=%b", i, bus.mem_timeout, s[i].to); end
            if (!s[i].out[5]) exp_stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        step_t s[$];
        s.push_back({4'b1000, E_HOLD, S_RUN, 1'b0});
        s.push_back({4'b1000, E_HOLD, S_RUN, 1'b0});
        s.push_back({4'b0000, E_RUN,  S_RUN, 1'b0});
        foreach (s[i]) begin
            {bus.hold, bus.jump_taken, bus.mem_req, bus.mem_ack} = s[i].in;
            #1;
            checks++; if (outs !== s[i].out) begin failures++; $display("FAIL hold_outs step=%0d got=%b exp=%b", i, outs, s[i].out); end
            checks++; if (bus.state !== s[i].st) begin failures++; $display("FAIL hold_state step=%0d got=%0d exp=%0d", i, bus.state, s[i].st); end
            checks++; if (bus.stall_cnt !== exp_stall) begin failures++; $display("FAIL hold_stall step=%0d got=%0d exp=%0d", i, bus.stall_cnt, exp_stall); end
            checks++; if (bus.mem_timeout !== s[i].to) begin failures++; $display("FAIL hold_timeout step=%0d got=%b exp=%b", i, bus.mem_timeout, s[i].to); end
            if (!s[i].out[5]) exp_stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_jump();
        step_t s[$];
        s.push_back({4'b0100, E_JUMP, S_RUN, 1'b0});
        s.push_back({4'b1100, E_BUB,  S_FL,  1'b0});
        s.push_back({4'b1000, E_BUB,  S_FL,  1'b0});
        s.push_back({4'b1000, E_BUB,  S_FL,  1'b0});
        s.push_back({4'b0000, E_RUN,  S_RUN, 1'b0});
        foreach (s[i]) begin
            {bus.hold, bus.jump_taken, bus.mem_req, bus.mem_ack} = s[i].in;
            #1;
            checks++; if (outs !== s[i].out) begin failures++; $display("FAIL jump_outs step=%0d got=%b exp=%b", i, outs, s[i].out); end
            checks++; if (bus.state !== s[i].st) begin failures++; $display("FAIL jump_state step=%0d got=%0d exp=%0d", i, bus.state, s[i].st); end
            checks++; if (bus.stall_cnt !== exp_stall) begin failures++; $display("FAIL jump_stall step=%0d got=%0d exp=%0d", i, bus.stall_cnt, exp_stall); end
            checks++; if (bus.mem_timeout !== s[i].to) begin failures++; $display("FAIL jump_timeout step=%0d got=%b exp=%b", i, bus.mem_timeout, s[i].to); end
            if (!s[i].out[5]) exp_stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_mem_ack();
        step_t s[$];
        s.push_back({4'b0011, E_RUN, S_RUN, 1'b0});
        s.push_back({4'b0010, E_OFF, S_RUN, 1'b0});
        for (int k = 0; k < 3; k++) s.push_back({4'b0010, E_OFF, S_MW, 1'b0});
        s.push_back({4'b0011, E_RUN, S_MW,  1'b0});
        s.push_back({4'b0000, E_RUN, S_RUN, 1'b0});
        foreach (s[i]) begin
            {bus.hold, bus.jump_taken, bus.mem_req, bus.mem_ack} = s[i].in;
            #1;
            checks++; if (outs !== s[i].out) begin failures++; $display("FAIL memack_outs step=%0d got=%b exp=%b", i, outs, s[i].out); end
            checks++; if (bus.state !== s[i].st) begin failures++; $display("FAIL memack_state step=%0d got=%0d exp=%0d", i, bus.state, s[i].st); end
            checks++; if (bus.stall_cnt !== exp_stall) begin failures++; $display("FAIL memack_stall step=%0d got=%0d exp=%0d", i, bus.stall_cnt, exp_stall); end
            checks++; if (bus.mem_timeout !== s[i].to) begin failures++; $display("FAIL memack_timeout step=%0d got=%b exp=%b", i, bus.mem_timeout, s[i].to); end
            if (!s[i].out[5]) exp_stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        step_t s[$];
        s.push_back({4'b0010, E_OFF, S_RUN, 1'b0});
        for (int k = 0; k < 14; k++) s.push_back({4'b0010, E_OFF, S_MW, 1'b0});
        s.push_back({4'b0010, E_RUN, S_MW,  1'b0});
        s.push_back({4'b0000, E_RUN, S_RUN, 1'b1});
        s.push_back({4'b1000, E_HOLD, S_RUN, 1'b1});
        s.push_back({4'b0000, E_RUN, S_RUN, 1'b1});
        foreach (s[i]) begin
            {bus.hold, bus.jump_taken, bus.mem_req, bus.mem_ack} = s[i].in;
            #1;
            checks++; if (outs !== s[i].out) begin failures++; $display("FAIL timeout_outs step=%0d got=%b exp=%b", i, outs, s[i].out); end
            checks++; if (bus.state !== s[i].st) begin failures++; $display("FAIL timeout_state step=%0d got=%0d exp=%0d", i, bus.state, s[i].st); end
            checks++; if (bus.stall_cnt !== exp_stall) begin failures++; $display("FAIL timeout_stall step=%0d got=%0d exp=%0d", i, bus.stall_cnt, exp_stall); end
            checks++; if (bus.mem_timeout !== s[i].to) begin failures++; $display("FAIL timeout_flag step=%0d got=%b exp=%b", i, bus.mem_timeout, s[i].to); end
            if (!s[i].out[5]) exp_stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_flush_stall();
        step_t s[$];
        s.push_back({4'b0100, E_JUMP, S_RUN, 1'b1});
        s.push_back({4'b0000, E_BUB,  S_FL,  1'b1});
        s.push_back({4'b0010, E_OFF,  S_FL,  1'b1});
        s.push_back({4'b0010, E_OFF,  S_MW,  1'b1});
        s.push_back({4'b0011, E_BUB,  S_MW,  1'b1});
        s.push_back({4'b0000, E_BUB,  S_FL,  1'b1});
        s.push_back({4'b0000, E_BUB,  S_FL,  1'b1});
        s.push_back({4'b0000, E_RUN,  S_RUN, 1'b1});
        s.push_back({4'b0010, E_OFF,  S_RUN, 1'b1});
        s.push_back({4'b0010, E_OFF,  S_MW,  1'b1});
        foreach (s[i]) begin
            {bus.hold, bus.jump_taken, bus.mem_req, bus.mem_ack} = s[i].in;
            #1;
            checks++; if (outs !== s[i].out) begin failures++; $display("FAIL fstall_outs step=%0d got=%b exp=%b", i, outs, s[i].out); end
            checks++; if (bus.state !== s[i].st) begin failures++; $display("FAIL fstall_state step=%0d got=%0d exp=%0d", i, bus.state, s[i].st); end
            checks++; if (bus.stall_cnt !== exp_stall) begin failures++; $display("FAIL fstall_stall step=%0d got=%0d exp=%0d", i, bus.stall_cnt, exp_stall); end
            checks++; if (bus.mem_timeout !== s[i].to) begin failures++; $display("FAIL fstall_timeout step=%0d got=%b exp=%b", i, bus.mem_timeout, s[i].to); end
            if (!s[i].out[5]) exp_stall++;
            @(negedge clk);
        end
        // Now sitting in MEMW with mem_req still pending: reset must abort at once.
        nreset = 1'b0;
        #1;
        checks++; if (bus.state !== S_ST) begin failures++; $display("FAIL abort_state got=%0d exp=%0d", bus.state, S_ST); end
        checks++; if (bus.stall_cnt !== 16'd0) begin failures++; $display("FAIL abort_stall got=%0d exp=0", bus.stall_cnt); end
        checks++; if (bus.mem_timeout !== 1'b0) begin failures++; $display("FAIL abort_timeout got=%b exp=0", bus.mem_timeout); end
    endtask

    initial begin
        nreset = 1'b0;
        {bus.hold, bus.jump_taken, bus.mem_req, bus.mem_ack} = 4'b0000;
        exp_stall = '0;
        test_reset();
        test_hold();
        test_jump();
        test_mem_ack();
        test_timeout();
        test_flush_stall();
        test_reset();
        test_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
